// File: rtl/fir_err_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module : fir_mon_pkg
// Brief  : State encoding and width helpers shared by the FIR error monitor.
// Rev    : 1.0
// ============================================================================
package fir_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int err_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int sq_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int sum_w(input int data_w, input int win_log2);
    return data_w + 1 + win_log2;
  endfunction

  function automatic int sq_sum_w(input int data_w, input int win_log2);
    return 2 * data_w + 1 + win_log2;
  endfunction

  function automatic int abs_w(input int data_w, input int win_log2);
    return data_w + win_log2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_err_monitor_if.sv
`default_nettype none
// ============================================================================
// Module : fir_err_monitor_if
// Brief  : Sample-pair input stream and statistics-record output stream.
// Rev    : 1.0
// ============================================================================
interface fir_err_monitor_if #(
  parameter int DATA_W   = 32,
  parameter int WIN_LOG2 = 10
);
  localparam int ERR_W    = fir_mon_pkg::err_w(DATA_W);
  localparam int SUM_W    = fir_mon_pkg::sum_w(DATA_W, WIN_LOG2);
  localparam int SQSUM_W  = fir_mon_pkg::sq_sum_w(DATA_W, WIN_LOG2);
  localparam int ABSSUM_W = fir_mon_pkg::abs_w(DATA_W, WIN_LOG2);

  logic                       in_valid;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   appr;
  logic signed [DATA_W-1:0]   accu;
  logic                       stat_valid;
  logic                       stat_ready;
  logic signed [SUM_W-1:0]    err_sum;
  logic signed [ERR_W-1:0]    err_mean;
  logic        [SQSUM_W-1:0]  err_sq_sum;
  logic        [ABSSUM_W-1:0] abs_sum;
  logic        [ERR_W-1:0]    max_abs_err;

  modport slave (
    input  in_valid, appr, accu, stat_ready,
    output in_ready, stat_valid, err_sum, err_mean, err_sq_sum, abs_sum, max_abs_err
  );

  modport master (
    output in_valid, appr, accu, stat_ready,
    input  in_ready, stat_valid, err_sum, err_mean, err_sq_sum, abs_sum, max_abs_err
  );
endinterface
`default_nettype wire

// File: rtl/fir_err_monitor_stage.sv
`default_nettype none
// ============================================================================
// Module : fir_err_stage
// Brief  : Two registered stages: difference/abs values, then the square.
// Rev    : 1.0
// ============================================================================
module fir_err_stage
  import fir_mon_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     in_fire,
  input  wire logic signed [DATA_W-1:0] appr,
  input  wire logic signed [DATA_W-1:0] accu,
  output logic                          s1_valid,
  output logic                          s2_valid,
  output logic signed [DATA_W:0]        s2_err,
  output logic        [DATA_W:0]        s2_abs_err,
  output logic        [DATA_W-1:0]      s2_abs_accu,
  output logic        [2*DATA_W:0]      s2_sq
);
  localparam int ERR_W = err_w(DATA_W);
  localparam int SQ_W  = sq_w(DATA_W);

  logic                    s1_valid_q, s1_valid_d;
  logic signed [ERR_W-1:0] s1_err_q, s1_err_d;
  logic [ERR_W-1:0]        s1_abs_err_q, s1_abs_err_d;
  logic [DATA_W-1:0]       s1_abs_accu_q, s1_abs_accu_d;
  logic                    s2_valid_q, s2_valid_d;
  logic signed [ERR_W-1:0] s2_err_q, s2_err_d;
  logic [ERR_W-1:0]        s2_abs_err_q, s2_abs_err_d;
  logic [DATA_W-1:0]       s2_abs_accu_q, s2_abs_accu_d;
  logic [SQ_W-1:0]         s2_sq_q, s2_sq_d;
  logic signed [ERR_W-1:0] w_diff;
  logic [SQ_W-1:0]         w_abs_ext;

  always_comb begin
    // One extra bit makes the difference exact for any input pair.
    w_diff        = {appr[DATA_W-1], appr} - {accu[DATA_W-1], accu};
    w_abs_ext     = {{(SQ_W-ERR_W){1'b0}}, s1_abs_err_q};
    s1_valid_d    = in_fire;
    s1_err_d      = s1_err_q;
    s1_abs_err_d  = s1_abs_err_q;
    s1_abs_accu_d = s1_abs_accu_q;
    if (in_fire) begin
      s1_err_d      = w_diff;
      s1_abs_err_d  = w_diff[ERR_W-1] ? -w_diff : w_diff;
      // -(-2^(DATA_W-1)) wraps to the same bit pattern, read as unsigned.
      s1_abs_accu_d = accu[DATA_W-1] ? -accu : accu;
    end
    s2_valid_d    = s1_valid_q;
    s2_err_d      = s2_err_q;
    s2_abs_err_d  = s2_abs_err_q;
    s2_abs_accu_d = s2_abs_accu_q;
    s2_sq_d       = s2_sq_q;
    if (s1_valid_q) begin
      s2_err_d      = s1_err_q;
      s2_abs_err_d  = s1_abs_err_q;
      s2_abs_accu_d = s1_abs_accu_q;
      s2_sq_d       = w_abs_ext * w_abs_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_err_q      <= '0;
      s1_abs_err_q  <= '0;
      s1_abs_accu_q <= '0;
      s2_valid_q    <= 1'b0;
      s2_err_q      <= '0;
      s2_abs_err_q  <= '0;
      s2_abs_accu_q <= '0;
      s2_sq_q       <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_err_q      <= s1_err_d;
      s1_abs_err_q  <= s1_abs_err_d;
      s1_abs_accu_q <= s1_abs_accu_d;
      s2_valid_q    <= s2_valid_d;
      s2_err_q      <= s2_err_d;
      s2_abs_err_q  <= s2_abs_err_d;
      s2_abs_accu_q <= s2_abs_accu_d;
      s2_sq_q       <= s2_sq_d;
    end
  end

  assign s1_valid    = s1_valid_q;
  assign s2_valid    = s2_valid_q;
  assign s2_err      = s2_err_q;
  assign s2_abs_err  = s2_abs_err_q;
  assign s2_abs_accu = s2_abs_accu_q;
  assign s2_sq       = s2_sq_q;

endmodule
`default_nettype wire

// File: rtl/fir_err_monitor.sv
`default_nettype none
// ============================================================================
// Module : fir_err_monitor
// Brief  : Windowed error statistics for an approximate/accurate FIR pair.
// Rev    : 1.0
// ============================================================================
module fir_err_monitor
  import fir_mon_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WIN_LOG2 = 10
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  output logic             busy,
  fir_err_monitor_if.slave bus
);
  localparam int ERR_W    = err_w(DATA_W);
  localparam int SQ_W     = sq_w(DATA_W);
  localparam int SUM_W    = sum_w(DATA_W, WIN_LOG2);
  localparam int SQSUM_W  = sq_sum_w(DATA_W, WIN_LOG2);
  localparam int ABSSUM_W = abs_w(DATA_W, WIN_LOG2);
  localparam int CNT_W    = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_N    = CNT_W'(1 << WIN_LOG2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic signed [SUM_W-1:0]    acc_err_q, acc_err_d;
  logic [SQSUM_W-1:0]         acc_sq_q, acc_sq_d;
  logic [ABSSUM_W-1:0]        acc_abs_q, acc_abs_d;
  logic [ERR_W-1:0]           acc_max_q, acc_max_d;
  logic signed [SUM_W-1:0]    out_sum_q, out_sum_d;
  logic signed [ERR_W-1:0]    out_mean_q, out_mean_d;
  logic [SQSUM_W-1:0]         out_sq_q, out_sq_d;
  logic [ABSSUM_W-1:0]        out_abs_q, out_abs_d;
  logic [ERR_W-1:0]           out_max_q, out_max_d;

  logic                       in_ready;
  logic                       fire;
  logic                       s1_valid;
  logic                       s2_valid;
  logic signed [ERR_W-1:0]    s2_err;
  logic [ERR_W-1:0]           s2_abs_err;
  logic [DATA_W-1:0]          s2_abs_accu;
  logic [SQ_W-1:0]            s2_sq;

  assign in_ready = (state_q == ACCUM) && (count_q < WIN_N);
  assign fire     = bus.in_valid && in_ready;

  fir_err_stage #(
    .DATA_W (DATA_W)
  ) u_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_fire     (fire),
    .appr        (bus.appr),
    .accu        (bus.accu),
    .s1_valid    (s1_valid),
    .s2_valid    (s2_valid),
    .s2_err      (s2_err),
    .s2_abs_err  (s2_abs_err),
    .s2_abs_accu (s2_abs_accu),
    .s2_sq       (s2_sq)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_err_d  = acc_err_q;
    acc_sq_d   = acc_sq_q;
    acc_abs_d  = acc_abs_q;
    acc_max_d  = acc_max_q;
    out_sum_d  = out_sum_q;
    out_mean_d = out_mean_q;
    out_sq_d   = out_sq_q;
    out_abs_d  = out_abs_q;
    out_max_d  = out_max_q;

    if (s2_valid) begin
      acc_err_d = acc_err_q + {{WIN_LOG2{s2_err[ERR_W-1]}}, s2_err};
      acc_sq_d  = acc_sq_q + {{WIN_LOG2{1'b0}}, s2_sq};
      acc_abs_d = acc_abs_q + {{WIN_LOG2{1'b0}}, s2_abs_accu};
      if (s2_abs_err > acc_max_q) begin
        acc_max_d = s2_abs_err;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          count_d   = '0;
          acc_err_d = '0;
          acc_sq_d  = '0;
          acc_abs_d = '0;
          acc_max_d = '0;
        end
      end
      ACCUM: begin
        if (fire) begin
          count_d = count_q + CNT_ONE;
          if (count_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Once stage 1 is empty, the final sample is being folded in this cycle.
        if (!s1_valid) begin
          state_d    = DONE;
          out_sum_d  = acc_err_d;
          out_mean_d = acc_err_d[SUM_W-1:WIN_LOG2];
          out_sq_d   = acc_sq_d;
          out_abs_d  = acc_abs_d;
          out_max_d  = acc_max_d;
        end
      end
      DONE: begin
        if (bus.stat_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_err_q  <= '0;
      acc_sq_q   <= '0;
      acc_abs_q  <= '0;
      acc_max_q  <= '0;
      out_sum_q  <= '0;
      out_mean_q <= '0;
      out_sq_q   <= '0;
      out_abs_q  <= '0;
      out_max_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_err_q  <= acc_err_d;
      acc_sq_q   <= acc_sq_d;
      acc_abs_q  <= acc_abs_d;
      acc_max_q  <= acc_max_d;
      out_sum_q  <= out_sum_d;
      out_mean_q <= out_mean_d;
      out_sq_q   <= out_sq_d;
      out_abs_q  <= out_abs_d;
      out_max_q  <= out_max_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign bus.in_ready    = in_ready;
  assign bus.stat_valid  = (state_q == DONE);
  assign bus.err_sum     = out_sum_q;
  assign bus.err_mean    = out_mean_q;
  assign bus.err_sq_sum  = out_sq_q;
  assign bus.abs_sum     = out_abs_q;
  assign bus.max_abs_err = out_max_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_err_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_fir_err_monitor
// Brief  : Directed vector bench for fir_err_monitor with N = 4.
// Rev    : 1.0
// ============================================================================
module tb_fir_err_monitor;
  localparam int DATA_W   = 8;
  localparam int WIN_LOG2 = 2;
  localparam int N        = 4;

  typedef struct {
    int     appr[4];
    int     accu[4];
    int     e_sum;
    int     e_mean;
    longint e_sq;
    int     a_sum;
    int     e_max;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;

  fir_err_monitor_if #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) bus ();

  fir_err_monitor #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int c, input logic v);
    int ta;
    int tc;
    ta = a;
    tc = c;
    bus.in_valid = v;
    bus.appr     = ta[DATA_W-1:0];
    bus.accu     = tc[DATA_W-1:0];
  endtask

  task automatic wait_stat(output int edges);
    edges = 0;
    while (!bus.stat_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic chk_stats(input string tag, input int s, input int m, input longint q,
                           input int ab, input int mx);
    chk({tag, ".err_sum"}, bus.err_sum, s);
    chk({tag, ".err_mean"}, bus.err_mean, m);
    chk({tag, ".err_sq_sum"}, bus.err_sq_sum, q);
    chk({tag, ".abs_sum"}, bus.abs_sum, ab);
    chk({tag, ".max_abs_err"}, bus.max_abs_err, mx);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic release_stat();
    bus.stat_ready = 1'b1;
    tick();
    bus.stat_ready = 1'b0;
  endtask

  task automatic run_window(input vec_t v, input string tag);
    int lat;
    pulse_start();
    for (int k = 0; k < N; k++) begin
      drive(v.appr[k], v.accu[k], 1'b1);
      chk({tag, ".in_ready"}, bus.in_ready, 1);
      tick();
    end
    drive(0, 0, 1'b0);
    wait_stat(lat);
    chk({tag, ".latency"}, lat, 2);
    chk_stats(tag, v.e_sum, v.e_mean, v.e_sq, v.a_sum, v.e_max);
    release_stat();
    chk({tag, ".busy_after"}, busy, 0);
    chk({tag, ".stat_valid_after"}, bus.stat_valid, 0);
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int c0, input int c1, input int c2, input int c3,
                              input int s, input int m, input longint q,
                              input int ab, input int mx);
    vec_t r;
    r.appr[0] = a0; r.appr[1] = a1; r.appr[2] = a2; r.appr[3] = a3;
    r.accu[0] = c0; r.accu[1] = c1; r.accu[2] = c2; r.accu[3] = c3;
    r.e_sum = s; r.e_mean = m; r.e_sq = q; r.a_sum = ab; r.e_max = mx;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[6];
    int   pat[7];
    int   pa[7];
    int   pc[7];
    int   taken;
    int   lat;

    vecs[0] = mk(10, -5, 0, 127, 10, -5, 0, 127, 0, 0, 0, 142, 0);
    vecs[1] = mk(1, -1, 3, -3, 0, 0, 0, 0, 0, 0, 20, 0, 3);
    vecs[2] = mk(-128, -128, -128, -128, 127, 127, 127, 127, -1020, -255, 260100, 508, 255);
    vecs[3] = mk(5, 0, 0, 0, 0, 0, 0, -2, 7, 1, 29, 2, 5);
    vecs[4] = mk(0, 0, 0, 0, 5, 2, 0, 0, -7, -2, 29, 7, 5);
    vecs[5] = mk(2, 2, 2, 2, 1, 1, 1, 1, 4, 1, 4, 4, 1);

    bus.in_valid   = 1'b0;
    bus.appr       = '0;
    bus.accu       = '0;
    bus.stat_ready = 1'b0;

    tick();
    tick();
    chk("rst.busy", busy, 0);
    chk("rst.in_ready", bus.in_ready, 0);
    chk("rst.stat_valid", bus.stat_valid, 0);
    chk_stats("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk("idle.in_ready", bus.in_ready, 0);

    for (int i = 0; i < 5; i++) begin
      run_window(vecs[i], $sformatf("vec%0d", i));
    end

    // Bubbles on in_valid, junk data in idle cycles, long stat_ready stall.
    pat = '{1, 0, 0, 1, 1, 0, 1};
    pa  = '{3, 100, 100, 5, -5, 100, 9};
    pc  = '{1, -50, -50, 1, 1, -50, 1};
    taken = 0;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      drive(pa[i], pc[i], pat[i] != 0);
      if (bus.in_valid && bus.in_ready) taken++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(100, -50, 1'b1);
      chk("bubble.in_ready_after4", bus.in_ready, 0);
      if (bus.in_valid && bus.in_ready) taken++;
      tick();
    end
    drive(0, 0, 1'b0);
    chk("bubble.taken", taken, 4);
    wait_stat(lat);
    chk("bubble.stat_valid", bus.stat_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("stall.stat_valid", bus.stat_valid, 1);
      chk("stall.err_sum", bus.err_sum, 8);
      tick();
    end
    chk_stats("bubble", 8, 2, 120, 4, 8);
    release_stat();
    chk("bubble.busy_after", busy, 0);
    chk("bubble.stat_valid_after", bus.stat_valid, 0);
    chk("idle.hold_sum", bus.err_sum, 8);
    chk("idle.hold_max", bus.max_abs_err, 8);

    // start during ACCUM and DONE must be ignored.
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1'b1);
      tick();
    end
    drive(0, 0, 1'b0);
    pulse_start();
    chk("ign.busy_accum", busy, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1'b1);
      tick();
    end
    drive(0, 0, 1'b0);
    wait_stat(lat);
    chk("ign.latency", lat, 2);
    chk_stats("ign", 4, 1, 4, 0, 1);
    pulse_start();
    chk("ign.stat_valid_done", bus.stat_valid, 1);
    chk("ign.err_sum_done", bus.err_sum, 4);
    start          = 1'b1;
    bus.stat_ready = 1'b1;
    tick();
    start          = 1'b0;
    bus.stat_ready = 1'b0;
    chk("ign.busy_release", busy, 0);
    chk("ign.in_ready_release", bus.in_ready, 0);
    tick();
    chk("ign.busy_idle", busy, 0);

    // Asynchronous reset mid-window discards the partial window.
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      drive(50, -50, 1'b1);
      tick();
    end
    drive(0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.in_ready", bus.in_ready, 0);
    chk("arst.stat_valid", bus.stat_valid, 0);
    chk_stats("arst", 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_window(vecs[5], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
